// File: rtl/screen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | screen_pkg : shared constants, read-FSM state type and address helper       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package screen_pkg;

  localparam int SCREEN_BASE    = 16384;
  localparam int DEF_H_ACTIVE   = 512;
  localparam int DEF_H_FRONT    = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BACK     = 48;
  localparam int DEF_V_ACTIVE   = 256;
  localparam int DEF_V_FRONT    = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BACK     = 33;
  localparam int WORDS_PER_ROW  = DEF_H_ACTIVE / 16;
  localparam int ADR_W          = 15;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_REQ  = 1'b1
  } rd_state_e;

  // Word address of (row, col); wraps in 15-bit unsigned arithmetic.
  function automatic logic [ADR_W-1:0] word_adr(input logic [ADR_W-1:0] row,
                                                input logic [ADR_W-1:0] col,
                                                input logic [ADR_W-1:0] wpr);
    return ADR_W'(SCREEN_BASE) + row * wpr + col;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_timing_gen : h/v counters, registered syncs/de, load & prefetch strobes|
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module sync_timing_gen #(
  parameter int H_ACTIVE = 512,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 256,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33
) (
  input  logic        clk,
  input  logic        rst,
  output logic        de,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        frame_start,
  output logic        active,
  output logic        load_stb,
  output logic        load_last,
  output logic        prefetch_stb,
  output logic [14:0] load_col,
  output logic [14:0] cur_row,
  output logic [14:0] next_row
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT       = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LAST_LOAD = HW'(H_ACTIVE - 16);
  localparam logic [HW-1:0] HS_BEG      = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] HS_END      = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [HW-1:0] H_PREF      = HW'(H_TOTAL - 16);
  localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT       = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG      = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] VS_END      = VW'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d, v_next;
  logic de_q, de_d, hsync_n_q, hsync_n_d, vsync_n_q, vsync_n_d, frame_start_q, frame_start_d;

  always_comb begin
    v_next        = (v_q == V_LAST) ? '0 : v_q + VW'(1);
    h_d           = (h_q == H_LAST) ? '0 : h_q + HW'(1);
    v_d           = (h_q == H_LAST) ? v_next : v_q;
    active        = (h_q < H_ACT) && (v_q < V_ACT);
    de_d          = active;
    hsync_n_d     = !((h_q >= HS_BEG) && (h_q < HS_END));
    vsync_n_d     = !((v_q >= VS_BEG) && (v_q < VS_END));
    frame_start_d = active && (h_q == '0) && (v_q == '0);
    load_stb      = active && (h_q[3:0] == 4'd0);
    load_last     = (h_q == H_LAST_LOAD);
    load_col      = 15'(h_q >> 4);
    prefetch_stb  = (h_q == H_PREF) && (v_next < V_ACT);
    cur_row       = 15'(v_q);
    next_row      = 15'(v_next);
  end

  // Starting on the last back-porch line lets line 0 be prefetched normally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q           <= '0;
      v_q           <= V_LAST;
      de_q          <= 1'b0;
      hsync_n_q     <= 1'b1;
      vsync_n_q     <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      de_q          <= de_d;
      hsync_n_q     <= hsync_n_d;
      vsync_n_q     <= vsync_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign de          = de_q;
  assign hsync_n     = hsync_n_q;
  assign vsync_n     = vsync_n_q;
  assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: rtl/screen_scanout.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | screen_scanout : framebuffer reader, prefetch buffer, pixel shifter         |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module screen_scanout
  import screen_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rd_req,
  output logic [14:0] rd_adr,
  input  logic        rd_valid,
  input  logic [15:0] rd_data,
  output logic        pix,
  output logic        de,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        frame_start,
  output logic        underrun
);
  localparam logic [14:0] WPR = 15'(H_ACTIVE / 16);

  logic        active, load_stb, load_last, prefetch_stb;
  logic [14:0] load_col, cur_row, next_row;

  sync_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) u_timing (
    .clk          (clk),
    .rst          (rst),
    .de           (de),
    .hsync_n      (hsync_n),
    .vsync_n      (vsync_n),
    .frame_start  (frame_start),
    .active       (active),
    .load_stb     (load_stb),
    .load_last    (load_last),
    .prefetch_stb (prefetch_stb),
    .load_col     (load_col),
    .cur_row      (cur_row),
    .next_row     (next_row)
  );

  rd_state_e   state_q, state_d;
  logic [14:0] rd_adr_q, rd_adr_d, pend_adr_q, pend_adr_d, need_adr_q, need_adr_d;
  logic        pend_q, pend_d, need_vld_q, need_vld_d, buf_vld_q, buf_vld_d;
  logic [15:0] buf_q, buf_d, shift_q, shift_d, load_word;
  logic        pix_q, pix_d, underrun_q, underrun_d;
  logic        new_req;
  logic [14:0] new_adr;

  always_comb begin
    state_d    = state_q;
    rd_adr_d   = rd_adr_q;
    pend_d     = pend_q;
    pend_adr_d = pend_adr_q;
    need_vld_d = need_vld_q;
    need_adr_d = need_adr_q;
    buf_d      = buf_q;
    buf_vld_d  = buf_vld_q;
    underrun_d = underrun_q;
    new_req    = 1'b0;
    new_adr    = '0;
    load_word  = shift_q;

    if (prefetch_stb) begin
      new_req    = 1'b1;
      new_adr    = word_adr(next_row, '0, WPR);
      need_vld_d = 1'b1;
      need_adr_d = new_adr;
    end

    if (load_stb) begin
      load_word  = buf_vld_q ? buf_q : '0;
      underrun_d = underrun_q | ~buf_vld_q;
      buf_vld_d  = 1'b0;
      need_vld_d = ~load_last;
      need_adr_d = word_adr(cur_row, load_col + 15'd1, WPR);
      new_req    = ~load_last;
      new_adr    = need_adr_d;
    end

    pix_d   = active & load_word[0];
    shift_d = active ? (load_word >> 1) : shift_q;

    // The address doubles as the tag: a completion that is not the word the
    // next load needs is stale and dropped.
    case (state_q)
      RD_IDLE: begin
        if (new_req || pend_q) begin
          state_d  = RD_REQ;
          rd_adr_d = new_req ? new_adr : pend_adr_q;
          pend_d   = 1'b0;
        end
      end
      RD_REQ: begin
        if (new_req) begin
          pend_d     = 1'b1;
          pend_adr_d = new_adr;
        end
        if (rd_valid) begin
          state_d = RD_IDLE;
          if (need_vld_d && (rd_adr_q == need_adr_d)) begin
            buf_d     = rd_data;
            buf_vld_d = 1'b1;
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RD_IDLE;
      rd_adr_q   <= '0;
      pend_q     <= 1'b0;
      pend_adr_q <= '0;
      need_vld_q <= 1'b0;
      need_adr_q <= '0;
      buf_q      <= '0;
      buf_vld_q  <= 1'b0;
      shift_q    <= '0;
      pix_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_adr_q   <= rd_adr_d;
      pend_q     <= pend_d;
      pend_adr_q <= pend_adr_d;
      need_vld_q <= need_vld_d;
      need_adr_q <= need_adr_d;
      buf_q      <= buf_d;
      buf_vld_q  <= buf_vld_d;
      shift_q    <= shift_d;
      pix_q      <= pix_d;
      underrun_q <= underrun_d;
    end
  end

  assign rd_req   = (state_q == RD_REQ);
  assign rd_adr   = rd_adr_q;
  assign pix      = pix_q;
  assign underrun = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_screen_scanout.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_screen_scanout : directed bench, full H timing with a short frame        |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_screen_scanout;
  localparam int HA = 512, HF = 16, HS = 96, HB = 48;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_valid = 1'b0;
  logic [15:0] rd_data = '0;
  logic        rd_req, pix, de, hsync_n, vsync_n, frame_start, underrun;
  logic [14:0] rd_adr;

  always #5 clk = ~clk;

  screen_scanout #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_adr(rd_adr), .rd_valid(rd_valid),
    .rd_data(rd_data), .pix(pix), .de(de), .hsync_n(hsync_n), .vsync_n(vsync_n),
    .frame_start(frame_start), .underrun(underrun)
  );

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Memory: answers lat cycles after rd_req is first seen.
  int lat = 1, mem_mode = 0, cnt = 0, n_last_done = 0;
  bit mem_en = 1'b1;

  function automatic logic [15:0] mem_word(input logic [14:0] a);
    if (mem_mode == 1) return 16'hFFFF;
    if (a == 15'd16384) return 16'h0001;
    if (a == 15'd16385) return 16'h8000;
    return 16'h0000;
  endfunction

  initial forever begin
    @(negedge clk);
    if (mem_en) begin
      if (rst || !rd_req || rd_valid) begin
        rd_valid = 1'b0;
        cnt = 0;
      end else begin
        cnt++;
        if (cnt >= lat) begin
          rd_valid = 1'b1;
          rd_data  = mem_word(rd_adr);
          if (rd_adr == 15'd16511) n_last_done++;
        end
      end
    end
  end

  int k, err_de, err_hs, err_vs, err_pix, err_fs, n_de, n_hs, n_vs, n_fs;
  int first_fs, first_ur, ur_drop, first_req_k, first_req_adr, n_req, bad_req, n_last_req;
  bit prev_req;

  task automatic clear();
    k = 0; err_de = 0; err_hs = 0; err_vs = 0; err_pix = 0; err_fs = 0;
    n_de = 0; n_hs = 0; n_vs = 0; n_fs = 0; first_fs = 0; first_ur = 0; ur_drop = 0;
    first_req_k = 0; first_req_adr = 0; n_req = 0; bad_req = 0; n_last_req = 0;
    n_last_done = 0; prev_req = 1'b0;
  endtask

  // mode 0: pixels only at x=0 and x=31 of line 0; 1: all active ones; 2: all zero.
  task automatic run(input int n, input int mode);
    int c, h, v;
    bit e_de, e_hs, e_vs, e_fs, e_pix;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      k++;
      c = k - 1;
      h = c % HT;
      v = (VT - 1 + c / HT) % VT;
      e_de  = (h < HA) && (v < VA);
      e_hs  = !((h >= HA + HF) && (h < HA + HF + HS));
      e_vs  = !((v >= VA + VF) && (v < VA + VF + VS));
      e_fs  = e_de && (h == 0) && (v == 0);
      e_pix = e_de && ((mode == 1) || ((mode == 0) && (v == 0) && ((h == 0) || (h == 31))));
      if (de !== e_de) err_de++;
      if (hsync_n !== e_hs) err_hs++;
      if (vsync_n !== e_vs) err_vs++;
      if (frame_start !== e_fs) err_fs++;
      if (pix !== e_pix) err_pix++;
      if (de) n_de++;
      if (!hsync_n) n_hs++;
      if (!vsync_n) n_vs++;
      if (frame_start) begin
        n_fs++;
        if (first_fs == 0) first_fs = k;
      end
      if (underrun) begin
        if (first_ur == 0) first_ur = k;
      end else if (first_ur != 0) ur_drop++;
      if (rd_req && !prev_req) begin
        n_req++;
        if (first_req_k == 0) begin
          first_req_k   = k;
          first_req_adr = int'(rd_adr);
        end
        if ((v >= VA) && (rd_adr != 15'd16384)) bad_req++;
        if (rd_adr == 15'd16511) n_last_req++;
      end
      prev_req = rd_req;
    end
  endtask

  task automatic check_reset(input string p);
    chk({p, "_pix"}, int'(pix), 0);
    chk({p, "_de"}, int'(de), 0);
    chk({p, "_hsync_n"}, int'(hsync_n), 1);
    chk({p, "_vsync_n"}, int'(vsync_n), 1);
    chk({p, "_frame_start"}, int'(frame_start), 0);
    chk({p, "_underrun"}, int'(underrun), 0);
    chk({p, "_rd_req"}, int'(rd_req), 0);
    chk({p, "_rd_adr"}, int'(rd_adr), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear();
  endtask

  initial begin
    bit found;
    clear();
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst = 1'b0;

    // Two frames, 1-cycle memory, two-pixel pattern on line 0.
    run(2 * VT * HT + 2, 0);
    chk("a_de_errs", err_de, 0);
    chk("a_hsync_errs", err_hs, 0);
    chk("a_vsync_errs", err_vs, 0);
    chk("a_fs_errs", err_fs, 0);
    chk("a_pix_errs", err_pix, 0);
    chk("a_de_count", n_de, 2 * HA * VA);
    chk("a_hsync_low_count", n_hs, 14 * HS);
    chk("a_vsync_low_count", n_vs, 2 * VS * HT);
    chk("a_fs_count", n_fs, 2);
    chk("a_first_fs_cycle", first_fs, HT + 1);
    chk("a_first_req_cycle", first_req_k, HT - 16 + 1);
    chk("a_first_req_adr", first_req_adr, 16384);
    chk("a_req_count", n_req, 2 * VA * 32);
    chk("a_req_in_blank", bad_req, 0);
    chk("a_last_word_req", n_last_req, 2);
    chk("a_last_word_done", n_last_done, 2);
    chk("a_no_underrun", first_ur, 0);

    // Latency 15: every word lands exactly in time.
    mem_mode = 1; lat = 15;
    do_reset();
    run(6 * HT, 1);
    chk("b_pix_errs", err_pix, 0);
    chk("b_de_errs", err_de, 0);
    chk("b_no_underrun", first_ur, 0);

    // Latency 20: every load misses, pixels blank, underrun sticky.
    lat = 20;
    do_reset();
    run(6 * HT, 2);
    chk("c_pix_errs", err_pix, 0);
    chk("c_first_underrun", first_ur, HT + 1);
    chk("c_underrun_drop", ur_drop, 0);

    // Reset while a request is outstanding on an active line.
    do_reset();
    run(HT + 40, 2);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      run(1, 2);
      if (rd_req) found = 1'b1;
    end
    chk("d_req_seen", int'(found), 1);
    chk("d_underrun_before_rst", int'(underrun), 1);
    #2 rst = 1'b1;
    #1;
    check_reset("d");
    mem_en   = 1'b0;
    rd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    clear();
    rd_valid = 1'b1;
    rd_data  = 16'hFFFF;
    run(3, 0);
    rd_valid = 1'b0;
    chk("d_idle_valid_ignored", int'(rd_req), 0);
    mem_mode = 0; lat = 1; cnt = 0; mem_en = 1'b1;
    run(2 * HT, 0);
    chk("d_pix_errs", err_pix, 0);
    chk("d_de_errs", err_de, 0);
    chk("d_first_req_cycle", first_req_k, HT - 16 + 1);
    chk("d_first_fs_cycle", first_fs, HT + 1);
    chk("d_no_underrun", first_ur, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
